// File: rtl/alu_share_arbiter.sv
// Round-robin sharing of one combinational ALU between two requesters.
// Requester 0 is the execute stage, requester 1 the address/branch helper.
// The granted request drives the ALU, and the result is captured in a
// one-entry response register tagged with requester id and tag.
//
// Ports:
//   clock, reset_n                 clock and asynchronous active-low reset
//   req{0,1}_valid/_ready          request handshake
//   req{0,1}_ctrl/_a/_b/_tag       request payload
//   alu_ctrl, alu_a, alu_b         drive to the shared ALU (zero when idle)
//   alu_result                     combinational ALU result
//   rsp_valid/_ready               response handshake
//   rsp_id, rsp_tag, rsp_result    captured response
module alu_share_arbiter #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned CTRL_W = 6,
  parameter int unsigned TAG_W  = 4
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [CTRL_W-1:0] req0_ctrl,
  input  logic [WIDTH-1:0]  req0_a,
  input  logic [WIDTH-1:0]  req0_b,
  input  logic [TAG_W-1:0]  req0_tag,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [CTRL_W-1:0] req1_ctrl,
  input  logic [WIDTH-1:0]  req1_a,
  input  logic [WIDTH-1:0]  req1_b,
  input  logic [TAG_W-1:0]  req1_tag,
  output logic [CTRL_W-1:0] alu_ctrl,
  output logic [WIDTH-1:0]  alu_a,
  output logic [WIDTH-1:0]  alu_b,
  input  logic [WIDTH-1:0]  alu_result,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_id,
  output logic [TAG_W-1:0]  rsp_tag,
  output logic [WIDTH-1:0]  rsp_result
);

  logic              last_grant_q, last_grant_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic              rsp_id_q, rsp_id_d;
  logic [TAG_W-1:0]  rsp_tag_q, rsp_tag_d;
  logic [WIDTH-1:0]  rsp_result_q, rsp_result_d;
  logic              can_issue;
  logic              gnt0, gnt1;

  // Grant and ALU operand mux.
  always_comb begin
    can_issue = !rsp_valid_q || rsp_ready;
    gnt0      = 1'b0;
    gnt1      = 1'b0;
    if (can_issue) begin
      // Requester 0 wins unless requester 1 also wants it and 0 went last.
      if (req0_valid && (!req1_valid || last_grant_q)) begin
        gnt0 = 1'b1;
      end else if (req1_valid) begin
        gnt1 = 1'b1;
      end
    end
    req0_ready = gnt0;
    req1_ready = gnt1;
    alu_ctrl   = '0;
    alu_a      = '0;
    alu_b      = '0;
    if (gnt0) begin
      alu_ctrl = req0_ctrl;
      alu_a    = req0_a;
      alu_b    = req0_b;
    end else if (gnt1) begin
      alu_ctrl = req1_ctrl;
      alu_a    = req1_a;
      alu_b    = req1_b;
    end
  end

  // Response register next state.
  always_comb begin
    last_grant_d = last_grant_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_id_d     = rsp_id_q;
    rsp_tag_d    = rsp_tag_q;
    rsp_result_d = rsp_result_q;
    if (gnt0 || gnt1) begin
      last_grant_d = gnt1;
      rsp_valid_d  = 1'b1;
      rsp_id_d     = gnt1;
      rsp_tag_d    = gnt1 ? req1_tag : req0_tag;
      rsp_result_d = alu_result;
    end else if (rsp_ready) begin
      // Drain only; data is left as-is.
      rsp_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      last_grant_q <= 1'b1;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= 1'b0;
      rsp_tag_q    <= '0;
      rsp_result_q <= '0;
    end else begin
      last_grant_q <= last_grant_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_id_q     <= rsp_id_d;
      rsp_tag_q    <= rsp_tag_d;
      rsp_result_q <= rsp_result_d;
    end
  end

  assign rsp_valid  = rsp_valid_q;
  assign rsp_id     = rsp_id_q;
  assign rsp_tag    = rsp_tag_q;
  assign rsp_result = rsp_result_q;

endmodule
